mpu_spi_responder: RTL and testbench
====================================

# mpu_spi_responder

- Synthesizable SPI slave that emulates the MPU9250 accelerometer register interface on the sensor side of the bus.
- Answers the single-register read and write transactions issued by the accel SPI master. It also supports burst transfers.
- Serves accel samples supplied on parallel inputs. It holds the writable configuration registers and exposes them as outputs.
- Used as the device under the bus in hardware-in-the-loop and FPGA self-test builds, in place of the physical MPU9250.

## Interface

Parameters:
- WHO_AM_I_VAL, 8'h71: value returned at address 0x75.
- PWR_MGMT_1_RST, 8'h01: reset value of register 0x6B.

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- SPI_SS_a  input  1  slave select from master, active-low.
- SPI_CK_a  input  1  SCLK from master, mode 3 (idles high).
- SPI_DO_a  input  1  master-out/slave-in data.
- SPI_DI_a  output  1  master-in/slave-out data.
- accel_x_in, accel_y_in, accel_z_in  input  16 each  sample words to serve.
- sample_valid  input  1  one-cycle pulse; captures the three accel inputs.
- pwr_mgmt_1  output  8  register 0x6B.
- int_pin_cfg  output  8  register 0x37.
- wr_strobe  output  1  one-cycle pulse per committed write byte.
- wr_addr  output  7  address of that write.
- wr_data  output  8  data of that write.

## Operation

Input synchronisation:
- SPI_SS_a, SPI_CK_a and SPI_DO_a each pass through a 2-flop synchroniser.
- SCLK rising and falling edges are detected on the synchronised SCLK.

Frame format:
- Bit 0 is R/W (1 = read), MSB first.
- Bits 1-7 are the address.
- Each following 8 bits form one data byte.

State machine:
- IDLE: entered while SS is high. Clears the bit counter and sets SPI_DI_a = 0. A falling SS moves to ADDR.
- ADDR: samples MOSI on each SCLK rise. After 8 rises, latches rw and addr and moves to DATA.
  - For a read, loads the tx shift register from the register map at addr.
- DATA: samples MOSI on SCLK rise and shifts MISO on SCLK fall.
  - Each 8th rise completes a byte.
  - For a write, the completed byte commits to addr.
  - For a read, the tx register reloads from addr+1.
  - addr then increments, wrapping 0x7F to 0x00.
- Any SS rise returns to IDLE immediately. A partial byte is discarded and no write occurs.

Register map:
- 0x3B-0x40: ACCEL_X_H/L, Y_H/L, Z_H/L, from the shadow snapshot. Read-only.
- 0x37: INT_PIN_CFG. R/W, reset 0x00.
- 0x6B: PWR_MGMT_1. R/W, reset PWR_MGMT_1_RST.
- 0x75: WHO_AM_I = WHO_AM_I_VAL. Read-only.
- All other addresses read 0x00. Writes to them and to read-only addresses are ignored, but wr_strobe still pulses.

Snapshot:
- A sample_valid pulse while in IDLE loads the shadow registers on the next clk.
- A sample_valid pulse while SS is low sets a pending flag. The pending sample is applied on the cycle SS returns high.
- A later pulse during the same frame overwrites the pending data.
- A frame therefore never sees a torn sample.

MISO behaviour:
- 0 during the address byte.
- In a write frame, 0 throughout.

## Timing

Reset values:
- SPI_DI_a = 0.
- pwr_mgmt_1 = PWR_MGMT_1_RST.
- int_pin_cfg = 0x00.
- wr_strobe = 0; wr_addr = 0; wr_data = 0.
- Shadow registers = 0; pending flag = 0.

Latencies:
- Edge detect is 2 clk after the pin toggles (synchroniser).
- SPI_DI_a updates 3 clk after the SCLK falling edge at the pin. This must fit in half an SCLK period.
- First read data bit (MSB) is driven on the SCLK fall after the 8th rise.
- Write commit: the register and wr_strobe/wr_addr/wr_data update 1 clk after the 16th (or 8n+8th) rise is detected. wr_strobe is high for exactly 1 clk.

Boundary conditions:
- SS rise on the same clk as the completing rise edge: the byte commits, then the block returns to IDLE.
- Reset asserted mid-frame: all state returns to reset values, and the frame is ignored until the next SS fall.
- SCLK edges while SS is high are ignored.

## Test plan

- Write frame 0x6B,0x00 -> pwr_mgmt_1 = 0x00; wr_strobe pulses once with wr_addr = 0x6B, wr_data = 0x00.
- Read frame 0xF5 (addr 0x75) -> MISO byte 2 = 0x71; pwr_mgmt_1 unchanged = 0x01.
- sample_valid with x = 0x1234, y = 0xABCD, z = 0x8001, then reads of 0x3B..0x40 -> 0x12, 0x34, 0xAB, 0xCD, 0x80, 0x01.
- Burst read starting at 0x3B for 6 data bytes -> same six bytes in order. A burst from 0x7F returns byte(0x7F) = 0x00, then byte(0x00) = 0x00.
- sample_valid (x = 0x5555) mid-read of 0x3B with old x = 0x1234 -> that frame returns 0x12. A read after SS rise returns 0x55.
- Write 0x37,0x02 aborted by SS rise after 12 bits -> int_pin_cfg stays 0x00 and no wr_strobe. A repeat complete frame gives 0x02.

Source files
------------

// File: rtl/mpu_spi_responder_if.sv
// SPI pin bundle between the accel SPI master and the MPU9250 emulator.
// Pin names follow the accel master's naming so board wiring reads 1:1.
interface mpu_spi_responder_if;
  logic SPI_SS_a;  // slave select, active-low
  logic SPI_CK_a;  // SCLK, mode 3 (idles high)
  logic SPI_DO_a;  // master-out / slave-in
  logic SPI_DI_a;  // master-in / slave-out

  modport master (output SPI_SS_a, SPI_CK_a, SPI_DO_a, input SPI_DI_a);
  modport slave  (input SPI_SS_a, SPI_CK_a, SPI_DO_a, output SPI_DI_a);
endinterface

// File: rtl/mpu_spi_responder.sv
// MPU9250 accelerometer register-interface emulator (SPI mode 3 slave).
// Oversamples the SPI pins with the system clock, decodes R/W + address,
// serves accel snapshots and WHO_AM_I, and holds the writable config regs.
module mpu_spi_responder #(
  parameter logic [7:0] WHO_AM_I_VAL   = 8'h71,
  parameter logic [7:0] PWR_MGMT_1_RST = 8'h01
) (
  input  logic                      clk,
  input  logic                      reset,
  mpu_spi_responder_if.slave        spi,
  input  logic [15:0]               accel_x_in,
  input  logic [15:0]               accel_y_in,
  input  logic [15:0]               accel_z_in,
  input  logic                      sample_valid,
  output logic [7:0]                pwr_mgmt_1,
  output logic [7:0]                int_pin_cfg,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr,
  output logic [7:0]                wr_data
);

  localparam logic [6:0] ADDR_ACCEL_XH  = 7'h3B;
  localparam logic [6:0] ADDR_ACCEL_XL  = 7'h3C;
  localparam logic [6:0] ADDR_ACCEL_YH  = 7'h3D;
  localparam logic [6:0] ADDR_ACCEL_YL  = 7'h3E;
  localparam logic [6:0] ADDR_ACCEL_ZH  = 7'h3F;
  localparam logic [6:0] ADDR_ACCEL_ZL  = 7'h40;
  localparam logic [6:0] ADDR_INT_PIN   = 7'h37;
  localparam logic [6:0] ADDR_PWR_MGMT  = 7'h6B;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h75;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;

  logic        ss_meta, ss_sync, ss_prev;
  logic        ck_meta, ck_sync, ck_prev;
  logic        do_meta, do_sync;
  logic        ck_rise, ck_fall, ss_fall;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        rw;
  logic [6:0]  addr;
  logic [6:0]  addr_next;
  logic [7:0]  tx_shift;
  logic        miso;

  logic [15:0] shadow_x, shadow_y, shadow_z;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        pending;

  // Two-flop synchronisers plus one history flop for edge detection.
  // The SS chain resets to 0 so that a frame already in progress when reset
  // releases never shows up as a falling SS: the block waits for a real
  // SS rise and fall before decoding again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ss_prev <= 1'b0;
      ck_meta <= 1'b1;
      ck_sync <= 1'b1;
      ck_prev <= 1'b1;
      do_meta <= 1'b0;
      do_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value
      // of its predecessor, which is what makes this a two-stage chain.
      ss_meta <= spi.SPI_SS_a;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
      ck_meta <= spi.SPI_CK_a;
      ck_sync <= ck_meta;
      ck_prev <= ck_sync;
      do_meta <= spi.SPI_DO_a;
      do_sync <= do_meta;
    end
  end

  assign ck_rise   = ck_sync & ~ck_prev;
  assign ck_fall   = ~ck_sync & ck_prev;
  assign ss_fall   = ss_prev & ~ss_sync;
  assign rx_byte   = {rx_shift, do_sync};
  assign byte_done = ck_rise && (bit_cnt == 3'd7);
  assign addr_next = addr + 7'd1;

  // Register-map read decode shared by the first load and burst reloads.
  function automatic logic [7:0] reg_read(input logic [6:0] a);
    logic [7:0] d;
    d = 8'h00;
    unique case (a)
      ADDR_ACCEL_XH: d = shadow_x[15:8];
      ADDR_ACCEL_XL: d = shadow_x[7:0];
      ADDR_ACCEL_YH: d = shadow_y[15:8];
      ADDR_ACCEL_YL: d = shadow_y[7:0];
      ADDR_ACCEL_ZH: d = shadow_z[15:8];
      ADDR_ACCEL_ZL: d = shadow_z[7:0];
      ADDR_INT_PIN:  d = int_pin_cfg;
      ADDR_PWR_MGMT: d = pwr_mgmt_1;
      ADDR_WHO_AM_I: d = WHO_AM_I_VAL;
      default:       d = 8'h00;
    endcase
    return d;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; SS high aborts any frame from any state.
  always_comb begin
    // NOTE: assigning the default first means every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = ADDR;
      ADDR:    if (ss_sync) state_d = IDLE;
               else if (byte_done) state_d = DATA;
      DATA:    if (ss_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit/byte datapath: shift MOSI in on rises, MISO out on falls, commit
  // writes and reload read data on each completed byte. A completing rise
  // seen together with SS high still commits before the frame closes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      rw          <= 1'b0;
      addr        <= 7'd0;
      tx_shift    <= 8'd0;
      miso        <= 1'b0;
      pwr_mgmt_1  <= PWR_MGMT_1_RST;
      int_pin_cfg <= 8'h00;
      wr_strobe   <= 1'b0;
      wr_addr     <= 7'd0;
      wr_data     <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      unique case (state_q)
        IDLE: begin
          bit_cnt <= 3'd0;
          miso    <= 1'b0;
        end
        ADDR: begin
          if (ck_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (byte_done) begin
              rw       <= rx_byte[7];
              addr     <= rx_byte[6:0];
              tx_shift <= rx_byte[7] ? reg_read(rx_byte[6:0]) : 8'h00;
            end
          end
        end
        DATA: begin
          if (ck_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (byte_done) begin
              if (rw) begin
                tx_shift <= reg_read(addr_next);
              end else begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= rx_byte;
                if (addr == ADDR_INT_PIN)  int_pin_cfg <= rx_byte;
                if (addr == ADDR_PWR_MGMT) pwr_mgmt_1  <= rx_byte;
              end
              addr <= addr_next;
            end
          end else if (ck_fall && !ss_sync) begin
            miso     <= rw & tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: begin
          bit_cnt <= 3'd0;
          miso    <= 1'b0;
        end
      endcase
    end
  end

  // Accel snapshot: load directly when idle, otherwise park the newest
  // sample and apply it as SS returns high so a frame never sees a torn one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_x <= 16'd0;
      shadow_y <= 16'd0;
      shadow_z <= 16'd0;
      pend_x   <= 16'd0;
      pend_y   <= 16'd0;
      pend_z   <= 16'd0;
      pending  <= 1'b0;
    end else if (state_q == IDLE) begin
      pending <= 1'b0;
      if (sample_valid) begin
        shadow_x <= accel_x_in;
        shadow_y <= accel_y_in;
        shadow_z <= accel_z_in;
      end
    end else if (ss_sync) begin
      pending <= 1'b0;
      if (sample_valid) begin
        shadow_x <= accel_x_in;
        shadow_y <= accel_y_in;
        shadow_z <= accel_z_in;
      end else if (pending) begin
        shadow_x <= pend_x;
        shadow_y <= pend_y;
        shadow_z <= pend_z;
      end
    end else if (sample_valid) begin
      pend_x  <= accel_x_in;
      pend_y  <= accel_y_in;
      pend_z  <= accel_z_in;
      pending <= 1'b1;
    end
  end

  assign spi.SPI_DI_a = miso;

endmodule

// File: tb/tb_mpu_spi_responder.sv
// Self-checking bench for mpu_spi_responder: bit-banged SPI mode 3 master,
// register-map reference model, directed scenarios plus randomized frames.
module tb_mpu_spi_responder;

  localparam int H = 8;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ax, ay, az;
  logic        sv;
  logic [7:0]  pwr_mgmt_1, int_pin_cfg, wr_data;
  logic        wr_strobe;
  logic [6:0]  wr_addr;

  always #5 clk = ~clk;

  mpu_spi_responder_if bus ();

  mpu_spi_responder #(.WHO_AM_I_VAL(8'h71), .PWR_MGMT_1_RST(8'h01)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi          (bus),
    .accel_x_in   (ax),
    .accel_y_in   (ay),
    .accel_z_in   (az),
    .sample_valid (sv),
    .pwr_mgmt_1   (pwr_mgmt_1),
    .int_pin_cfg  (int_pin_cfg),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  tx_buf [0:15];
  logic [7:0]  rx_buf [0:15];
  logic [15:0] nx, ny, nz;  // sample pulsed in the middle of a frame

  // Reference model state
  logic [7:0]  m_pwr, m_int;
  logic [15:0] m_x, m_y, m_z;
  logic [14:0] got_wr[$];
  logic [14:0] exp_wr[$];

  // Collect every write strobe seen on the bus.
  always @(negedge clk) if (wr_strobe === 1'b1) got_wr.push_back({wr_addr, wr_data});

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    case (a)
      7'h3B:   return m_x[15:8];
      7'h3C:   return m_x[7:0];
      7'h3D:   return m_y[15:8];
      7'h3E:   return m_y[7:0];
      7'h3F:   return m_z[15:8];
      7'h40:   return m_z[7:0];
      7'h37:   return m_int;
      7'h6B:   return m_pwr;
      7'h75:   return 8'h71;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    m_pwr = 8'h01; m_int = 8'h00;
    m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
    got_wr.delete(); exp_wr.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  32'(bus.SPI_DI_a), 32'd0);
    check({tag, "_pwr"},   32'(pwr_mgmt_1),   32'h01);
    check({tag, "_int"},   32'(int_pin_cfg),  32'h00);
    check({tag, "_wstb"},  32'(wr_strobe),    32'd0);
    check({tag, "_waddr"}, 32'(wr_addr),      32'd0);
    check({tag, "_wdata"}, 32'(wr_data),      32'd0);
  endtask

  task automatic sample_idle(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    ax = x; ay = y; az = z; sv = 1'b1;
    wait_clks(1);
    sv = 1'b0;
    wait_clks(1);
    m_x = x; m_y = y; m_z = z;
  endtask

  // Drive one SS-low period of nbits SCLK cycles, capturing MISO before each rise.
  task automatic run_bits(input int nbits, input int sample_bit, input int reset_bit,
                          input bit ss_with_last);
    bus.SPI_SS_a = 1'b0;
    wait_clks(H);
    for (int k = 0; k < nbits; k++) begin
      if (k == reset_bit) begin
        reset = 1'b0;
        wait_clks(3);
        check_reset_outputs("midreset");
        reset = 1'b1;
        wait_clks(2);
      end
      bus.SPI_CK_a = 1'b0;
      bus.SPI_DO_a = tx_buf[k / 8][7 - (k % 8)];
      if (k == sample_bit) begin
        ax = nx; ay = ny; az = nz; sv = 1'b1;
        wait_clks(1);
        sv = 1'b0;
        wait_clks(H - 1);
      end else begin
        wait_clks(H);
      end
      rx_buf[k / 8][7 - (k % 8)] = bus.SPI_DI_a;
      if (k == nbits - 1 && ss_with_last) bus.SPI_SS_a = 1'b1;
      bus.SPI_CK_a = 1'b1;
      wait_clks(H);
    end
    bus.SPI_SS_a = 1'b1;
    wait_clks(H);
  endtask

  task automatic check_wr(input string tag);
    check({tag, "_wcount"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
    got_wr.delete();
    exp_wr.delete();
  endtask

  // One full frame with model-based expectations.
  task automatic frame(input bit rw, input logic [6:0] a, input int ndata, input int extra,
                       input logic [7:0] d0, input int sample_bit, input int reset_bit,
                       input bit ss_with_last, input string tag);
    logic [6:0] ai;
    tx_buf[0] = {rw, a};
    for (int i = 1; i < 16; i++) tx_buf[i] = 8'($urandom);
    tx_buf[1] = d0;
    for (int i = 0; i < 16; i++) rx_buf[i] = 8'h00;
    run_bits(8 * (ndata + 1) + extra, sample_bit, reset_bit, ss_with_last);
    check({tag, "_miso_addr"}, 32'(rx_buf[0]), 32'h00);
    if (reset_bit >= 0) begin
      m_reset();
      for (int i = 0; i < ndata; i++)
        check($sformatf("%s_ignored%0d", tag, i), 32'(rx_buf[i + 1]), 32'h00);
    end else begin
      for (int i = 0; i < ndata; i++) begin
        ai = a + 7'(i);
        if (rw) begin
          check($sformatf("%s_rd%0d", tag, i), 32'(rx_buf[i + 1]), 32'(m_read(ai)));
        end else begin
          check($sformatf("%s_miso%0d", tag, i), 32'(rx_buf[i + 1]), 32'h00);
          if (ai == 7'h37) m_int = tx_buf[i + 1];
          if (ai == 7'h6B) m_pwr = tx_buf[i + 1];
          exp_wr.push_back({ai, tx_buf[i + 1]});
        end
      end
      if (sample_bit >= 0) begin
        m_x = nx; m_y = ny; m_z = nz;
      end
    end
    check_wr(tag);
    check({tag, "_pwr"}, 32'(pwr_mgmt_1),  32'(m_pwr));
    check({tag, "_int"}, 32'(int_pin_cfg), 32'(m_int));
  endtask

  initial begin
    logic [6:0] ra;
    int rw_sel, nd, ex, sb, tot;

    reset = 1'b0;
    bus.SPI_SS_a = 1'b1; bus.SPI_CK_a = 1'b1; bus.SPI_DO_a = 1'b0;
    sv = 1'b0; ax = 16'h0; ay = 16'h0; az = 16'h0;
    nx = 16'h0; ny = 16'h0; nz = 16'h0;
    m_reset();
    wait_clks(4);
    check_reset_outputs("reset");
    reset = 1'b1;
    wait_clks(4);

    // Shadow registers come out of reset as zero
    frame(1'b1, 7'h3B, 6, 0, 8'h00, -1, -1, 1'b0, "shadow_reset");
    // WHO_AM_I read leaves PWR_MGMT_1 untouched
    frame(1'b1, 7'h75, 1, 0, 8'h00, -1, -1, 1'b0, "who_am_i");
    check("who_am_i_val", 32'(rx_buf[1]), 32'h71);
    // Write PWR_MGMT_1 = 0
    frame(1'b0, 7'h6B, 1, 0, 8'h00, -1, -1, 1'b0, "wr_pwr");
    // Snapshot then single reads of each accel byte
    sample_idle(16'h1234, 16'hABCD, 16'h8001);
    for (int i = 0; i < 6; i++)
      frame(1'b1, 7'h3B + 7'(i), 1, 0, 8'h00, -1, -1, 1'b0, $sformatf("accel_single%0d", i));
    // Burst over the accel block and across the address wrap
    frame(1'b1, 7'h3B, 6, 0, 8'h00, -1, -1, 1'b0, "accel_burst");
    check("accel_burst_zl", 32'(rx_buf[6]), 32'h01);
    frame(1'b1, 7'h7F, 2, 0, 8'h00, -1, -1, 1'b0, "wrap_burst");
    // Mid-frame sample is deferred until SS rises
    nx = 16'h5555; ny = 16'h6666; nz = 16'h7777;
    frame(1'b1, 7'h3B, 1, 0, 8'h00, 4, -1, 1'b0, "mid_sample");
    check("mid_sample_old", 32'(rx_buf[1]), 32'h12);
    frame(1'b1, 7'h3B, 1, 0, 8'h00, -1, -1, 1'b0, "after_sample");
    check("after_sample_new", 32'(rx_buf[1]), 32'h55);
    // Aborted write after 12 bits, then a complete one
    frame(1'b0, 7'h37, 0, 4, 8'h02, -1, -1, 1'b0, "abort_wr");
    frame(1'b0, 7'h37, 1, 0, 8'h02, -1, -1, 1'b0, "full_wr");
    // SS rising together with the completing rise still commits
    frame(1'b0, 7'h37, 1, 0, 8'h3C, -1, -1, 1'b1, "ss_same_edge");
    // SCLK toggling with SS high is ignored
    for (int k = 0; k < 16; k++) begin
      bus.SPI_CK_a = 1'b0; bus.SPI_DO_a = 1'($urandom); wait_clks(H);
      bus.SPI_CK_a = 1'b1; wait_clks(H);
    end
    check_wr("ck_ss_high");
    check("ck_ss_high_pwr", 32'(pwr_mgmt_1), 32'(m_pwr));
    // Reset in the middle of a write frame: frame is ignored
    frame(1'b0, 7'h6B, 1, 0, 8'hA5, -1, 10, 1'b0, "mid_reset");
    frame(1'b1, 7'h6B, 1, 0, 8'h00, -1, -1, 1'b0, "post_reset_rd");

    // Randomized frames against the model
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0)
        sample_idle(16'($urandom), 16'($urandom), 16'($urandom));
      rw_sel = $urandom_range(0, 4);
      case ($urandom_range(0, 4))
        0:       ra = 7'h37;
        1:       ra = 7'h6B;
        2:       ra = 7'h3A + 7'($urandom_range(0, 6));
        3:       ra = 7'h75;
        default: ra = 7'($urandom);
      endcase
      nd  = $urandom_range(1, 5);
      ex  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      tot = 8 * (nd + 1) + ex;
      sb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot - 1) : -1;
      nx = 16'($urandom); ny = 16'($urandom); nz = 16'($urandom);
      frame(rw_sel < 2 ? 1'b0 : 1'b1, ra, nd, ex, 8'($urandom), sb, -1, 1'b0,
            $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
